// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if
//   Groups the data path and display pins of seven_seg_scan_driver into one
//   bundle. The clock and reset are not part of it.
//   Modports:
//     master : drives i_Value / i_Load / i_Blank and observes the display outputs
//     slave  : the driver itself
//   Signals:
//     i_Value     4*NUM_DIGITS  hex nibbles, nibble k shown on digit k
//     i_Load      1             one-cycle strobe that stages i_Value
//     i_Blank     NUM_DIGITS    per-digit blank mask (1 = dark)
//     o_Segments  7             [6]=A .. [0]=G
//     o_Digit_En  NUM_DIGITS    one-hot digit enable, or all zero
//     o_Digit_Idx IDX_W         index of the digit slot being scanned
//     o_Frame     1             pulse on the first cycle of the digit-0 slot
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2);

  logic [4*NUM_DIGITS-1:0] i_Value;
  logic                    i_Load;
  logic [NUM_DIGITS-1:0]   i_Blank;
  logic [6:0]              o_Segments;
  logic [NUM_DIGITS-1:0]   o_Digit_En;
  logic [IDX_W-1:0]        o_Digit_Idx;
  logic                    o_Frame;

  modport master (
    output i_Value, i_Load, i_Blank,
    input  o_Segments, o_Digit_En, o_Digit_Idx, o_Frame
  );

  modport slave (
    input  i_Value, i_Load, i_Blank,
    output o_Segments, o_Digit_En, o_Digit_Idx, o_Frame
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-segment 7-segment digits.
//   Each digit gets a slot of CLKS_PER_DIGIT clocks. The first DEAD_CLKS
//   clocks of a slot keep every enable off, so the previous digit does not
//   ghost. New values are staged and move into the display register only at
//   a frame boundary, which means one frame never shows a mix of two values.
//   Ports:
//     i_Clk    system clock
//     i_Rst_L  asynchronous active-low reset
//     bus      seven_seg_scan_driver_if.slave (value/load/blank in, display out)
//   Optional feature:
//     SEVENSEG_LEADING_ZERO_BLANK_EN  when defined, digits above the most
//       significant nonzero nibble are blanked. Digit 0 is never blanked this way.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int DEAD_CLKS      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  seven_seg_scan_driver_if.slave  bus
);
  localparam int         CNT_W   = $clog2(CLKS_PER_DIGIT);
  localparam int         IDX_W   = $clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Segment pattern A..G with lit = 1. Polarity is applied later.
  function automatic logic [6:0] hex_enc(input logic [3:0] nib);
    case (nib)
      4'h0: hex_enc = 7'h7E;  4'h1: hex_enc = 7'h30;
      4'h2: hex_enc = 7'h6D;  4'h3: hex_enc = 7'h79;
      4'h4: hex_enc = 7'h33;  4'h5: hex_enc = 7'h5B;
      4'h6: hex_enc = 7'h5F;  4'h7: hex_enc = 7'h70;
      4'h8: hex_enc = 7'h7F;  4'h9: hex_enc = 7'h7B;
      4'hA: hex_enc = 7'h77;  4'hB: hex_enc = 7'h1F;
      4'hC: hex_enc = 7'h4E;  4'hD: hex_enc = 7'h3D;
      4'hE: hex_enc = 7'h4F;  default: hex_enc = 7'h47;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] staged_q, staged_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic                    staged_vld_q, staged_vld_d;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    frame_q;

  logic                    wrap, boundary;
  logic [NUM_DIGITS-1:0]   sel_d;      // one-hot of the slot being entered
  logic [NUM_DIGITS-1:0]   auto_blank; // leading-zero blank, from display_d
  logic [3:0]              nib_d;
  logic                    blank_d;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   en_d;

  assign wrap     = (cnt_q == CNT_W'(CLKS_PER_DIGIT - 1));
  assign boundary = wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Slot counter, digit index and the staging/display registers.
  always_comb begin
    cnt_d        = wrap ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    staged_d     = staged_q;
    display_d    = display_q;
    staged_vld_d = staged_vld_q;
    if (wrap)
      idx_d = boundary ? '0 : idx_q + 1'b1;
    if (boundary) begin
      // A load on the boundary cycle goes straight to the display and
      // replaces anything still staged.
      if (bus.i_Load)
        display_d = bus.i_Value;
      else if (staged_vld_q)
        display_d = staged_q;
      staged_vld_d = 1'b0;
    end else if (bus.i_Load) begin
      staged_d     = bus.i_Value;
      staged_vld_d = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign sel_d[k] = (idx_d == IDX_W'(k));
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (k == 0) begin : g_lsd
      assign auto_blank[k] = 1'b0;
    end else begin : g_upper
      assign auto_blank[k] = (display_d[4*NUM_DIGITS-1:4*k] == '0);
    end
`else
    assign auto_blank[k] = 1'b0;
`endif
  end

  // Select the nibble and blank bit for the slot that starts on the next edge.
  always_comb begin
    nib_d   = '0;
    blank_d = |(sel_d & (bus.i_Blank | auto_blank));
    for (int k = 0; k < NUM_DIGITS; k++)
      if (sel_d[k]) nib_d = display_d[4*k +: 4];
    seg_d = blank_d ? SEG_OFF
                    : (SEG_ACTIVE_LOW ? ~hex_enc(nib_d) : hex_enc(nib_d));
    en_d  = (int'(cnt_d) >= DEAD_CLKS) ? sel_d : '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      staged_q     <= '0;
      display_q    <= '0;
      staged_vld_q <= 1'b0;
      seg_q        <= SEG_OFF;
      en_q         <= '0;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staged_q     <= staged_d;
      display_q    <= display_d;
      staged_vld_q <= staged_vld_d;
      en_q         <= en_d;
      frame_q      <= boundary;
      // Segments only move at a slot change, together with the index.
      if (wrap) seg_q <= seg_d;
    end
  end

  assign bus.o_Segments  = seg_q;
  assign bus.o_Digit_En  = en_q;
  assign bus.o_Digit_Idx = idx_q;
  assign bus.o_Frame     = frame_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(8), .DEAD_CLKS(1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop at the negedge where o_Frame is high, which is cycle 0 of slot 0.
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_Frame === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL frame_timeout got=none exp=pulse"); end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.i_Value = v; bus.i_Load = 1'b1;
    @(negedge clk);
    bus.i_Load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.i_Value = '0; bus.i_Load = 1'b0; bus.i_Blank = '0;
    step(3);
    total++; if (bus.o_Segments !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", bus.o_Segments); end
    total++; if (bus.o_Digit_En !== 4'b0000) begin bad++; $display("FAIL reset_en got=%b exp=0000", bus.o_Digit_En); end
    total++; if (bus.o_Digit_Idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.o_Digit_Idx); end
    total++; if (bus.o_Frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", bus.o_Frame); end
    rst_n = 1'b1;
    step(7);
    total++; if (bus.o_Digit_Idx !== 2'd0) begin bad++; $display("FAIL first_slot_idx got=%0d exp=0", bus.o_Digit_Idx); end
    total++; if (bus.o_Digit_En !== 4'b0001) begin bad++; $display("FAIL first_slot_en got=%b exp=0001", bus.o_Digit_En); end
    step(1);
    total++; if (bus.o_Digit_Idx !== 2'd1) begin bad++; $display("FAIL first_wrap_idx got=%0d exp=1", bus.o_Digit_Idx); end
    total++; if (bus.o_Digit_En !== 4'b0000) begin bad++; $display("FAIL first_wrap_dead got=%b exp=0000", bus.o_Digit_En); end
  endtask

  task automatic test_load();
    pulse_load(16'h12AF);
    wait_frame();
    total++; if (bus.o_Segments !== 7'h38) begin bad++; $display("FAIL load_d0_seg got=%h exp=38", bus.o_Segments); end
    total++; if (bus.o_Digit_En !== 4'b0000) begin bad++; $display("FAIL load_d0_dead got=%b exp=0000", bus.o_Digit_En); end
    for (int c = 1; c < 8; c++) begin
      step(1);
      total++; if (bus.o_Digit_En !== 4'b0001) begin bad++; $display("FAIL load_d0_en c=%0d got=%b exp=0001", c, bus.o_Digit_En); end
    end
    step(1);
    total++; if (bus.o_Segments !== 7'h08) begin bad++; $display("FAIL load_d1_seg got=%h exp=08", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== 7'h12) begin bad++; $display("FAIL load_d2_seg got=%h exp=12", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Digit_Idx !== 2'd3) begin bad++; $display("FAIL load_d3_idx got=%0d exp=3", bus.o_Digit_Idx); end
    total++; if (bus.o_Segments !== 7'h4F) begin bad++; $display("FAIL load_d3_seg got=%h exp=4f", bus.o_Segments); end
    wait_frame();
    total++; if (bus.o_Segments !== 7'h38) begin bad++; $display("FAIL load_frame2_seg got=%h exp=38", bus.o_Segments); end
  endtask

  // Starts at slot 0 cycle 0. The old value 12AF must hold until the boundary.
  task automatic test_staging();
    step(4);
    pulse_load(16'h1111);
    step(4);
    total++; if (bus.o_Segments !== 7'h08) begin bad++; $display("FAIL stage_hold_d1 got=%h exp=08", bus.o_Segments); end
    step(7);
    pulse_load(16'h2222);
    step(7);
    total++; if (bus.o_Segments !== 7'h4F) begin bad++; $display("FAIL stage_hold_d3 got=%h exp=4f", bus.o_Segments); end
    total++; if (bus.o_Frame !== 1'b0) begin bad++; $display("FAIL stage_no_frame got=%b exp=0", bus.o_Frame); end
    wait_frame();
    total++; if (bus.o_Segments !== 7'h12) begin bad++; $display("FAIL stage_d0 got=%h exp=12", bus.o_Segments); end
    for (int d = 1; d < 4; d++) begin
      step(8);
      total++; if (bus.o_Segments !== 7'h12) begin bad++; $display("FAIL stage_d%0d got=%h exp=12", d, bus.o_Segments); end
    end
  endtask

  task automatic test_boundary_load();
    wait_frame();
    step(31);
    total++; if (bus.o_Digit_Idx !== 2'd3) begin bad++; $display("FAIL bnd_pre_idx got=%0d exp=3", bus.o_Digit_Idx); end
    pulse_load(16'h0005);
    total++; if (bus.o_Frame !== 1'b1) begin bad++; $display("FAIL bnd_frame got=%b exp=1", bus.o_Frame); end
    total++; if (bus.o_Segments !== 7'h24) begin bad++; $display("FAIL bnd_d0_seg got=%h exp=24", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== (LZB ? 7'h7F : 7'h01)) begin bad++; $display("FAIL bnd_d1_seg got=%h exp=%h", bus.o_Segments, LZB ? 7'h7F : 7'h01); end
  endtask

  task automatic test_blank();
    pulse_load(16'h8888);
    bus.i_Blank = 4'b0100;
    wait_frame();
    total++; if (bus.o_Segments !== 7'h00) begin bad++; $display("FAIL blank_d0_seg got=%h exp=00", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== 7'h00) begin bad++; $display("FAIL blank_d1_seg got=%h exp=00", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== 7'h7F) begin bad++; $display("FAIL blank_d2_seg got=%h exp=7f", bus.o_Segments); end
    total++; if (bus.o_Digit_En !== 4'b0000) begin bad++; $display("FAIL blank_d2_dead got=%b exp=0000", bus.o_Digit_En); end
    step(1);
    total++; if (bus.o_Digit_En !== 4'b0100) begin bad++; $display("FAIL blank_d2_en got=%b exp=0100", bus.o_Digit_En); end
    total++; if (bus.o_Segments !== 7'h7F) begin bad++; $display("FAIL blank_d2_seg_c1 got=%h exp=7f", bus.o_Segments); end
    bus.i_Blank = 4'b0000;
    step(7);
    total++; if (bus.o_Segments !== 7'h00) begin bad++; $display("FAIL blank_d3_seg got=%h exp=00", bus.o_Segments); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] z;
    z = LZB ? 7'h7F : 7'h01;
    pulse_load(16'h0030);
    wait_frame();
    total++; if (bus.o_Segments !== 7'h01) begin bad++; $display("FAIL lz_d0 got=%h exp=01", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== 7'h06) begin bad++; $display("FAIL lz_d1 got=%h exp=06", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== z) begin bad++; $display("FAIL lz_d2 got=%h exp=%h", bus.o_Segments, z); end
    step(8);
    total++; if (bus.o_Segments !== z) begin bad++; $display("FAIL lz_d3 got=%h exp=%h", bus.o_Segments, z); end
    pulse_load(16'h0000);
    wait_frame();
    total++; if (bus.o_Segments !== 7'h01) begin bad++; $display("FAIL lz0_d0 got=%h exp=01", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== z) begin bad++; $display("FAIL lz0_d1 got=%h exp=%h", bus.o_Segments, z); end
  endtask

  task automatic test_reset_mid();
    wait_frame();
    pulse_load(16'h1234);
    step(18);
    total++; if (bus.o_Digit_En !== 4'b0100) begin bad++; $display("FAIL rmid_pre_en got=%b exp=0100", bus.o_Digit_En); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.o_Segments !== 7'h7F) begin bad++; $display("FAIL rmid_seg got=%h exp=7f", bus.o_Segments); end
    total++; if (bus.o_Digit_En !== 4'b0000) begin bad++; $display("FAIL rmid_en got=%b exp=0000", bus.o_Digit_En); end
    total++; if (bus.o_Digit_Idx !== 2'd0) begin bad++; $display("FAIL rmid_idx got=%0d exp=0", bus.o_Digit_Idx); end
    step(2);
    rst_n = 1'b1;
    wait_frame();
    total++; if (bus.o_Segments !== 7'h01) begin bad++; $display("FAIL rmid_discard_d0 got=%h exp=01", bus.o_Segments); end
    step(8);
    total++; if (bus.o_Segments !== (LZB ? 7'h7F : 7'h01)) begin bad++; $display("FAIL rmid_discard_d1 got=%h exp=%h", bus.o_Segments, LZB ? 7'h7F : 7'h01); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_staging();
    test_boundary_load();
    test_blank();
    test_leading_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
